pingpong_counter: RTL

- Parametrised up/down counter with runtime bounds, step size and four modes: up-wrap, down-wrap, bounce (ping-pong) and hold.
- Next generation of the fixed 4-bit bounce counter. Used by display animation, power-level sweeps and timer sequencing in the microwave controller.
- Adds parallel load, direction and terminal-count status, and a saturating count of completed bounce laps.

---
 rtl/pingpong_pkg.sv | 14 +
 rtl/pingpong_counter_step_calc.sv | 109 ++++++++++
 rtl/pingpong_counter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared encodings for the pingpong_counter block.
//   MODE_*  : two-bit counting mode as driven on the mode port.
//   DIR_*   : one-bit direction as reported on the dir port.
package pingpong_pkg;

  localparam logic [1:0] MODE_UPWRAP = 2'b00;
  localparam logic [1:0] MODE_DNWRAP = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pingpong_counter_step_calc.sv
// pp_step_calc: purely combinational next-value logic for one enabled
// advance of the pingpong counter with valid bounds (lo < hi).
// Ports:
//   count, dir  : current registered value and direction
//   mode        : counting mode (see pingpong_pkg)
//   lo, hi      : inclusive bounds
//   s           : effective step, already forced non-zero by the caller
//   next_count  : value after this advance
//   next_dir    : direction after this advance
//   next_tc     : this advance is a wrap or a turnaround
//   lap_inc     : this advance is the bounce turnaround at lo
module pp_step_calc
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             next_tc,
  output logic             lap_inc
);

  // One extra bit so count+s and lo+s never wrap silently.
  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   lo_x;
  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   s_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_plus_s;
  logic [WIDTH-1:0] up_next;   // min(count+s, hi)
  logic [WIDTH-1:0] dn_next;   // max(count-s, lo)

  always_comb begin
    count_x   = {1'b0, count};
    lo_x      = {1'b0, lo};
    hi_x      = {1'b0, hi};
    s_x       = {1'b0, s};
    up_sum    = count_x + s_x;
    lo_plus_s = lo_x + s_x;
    up_next   = (up_sum > hi_x) ? hi : up_sum[WIDTH-1:0];
    // count - lo >= s  <=>  count >= lo + s
    dn_next   = (count_x >= lo_plus_s) ? (count - s) : lo;
  end

  always_comb begin
    next_count = count;
    next_dir   = dir;
    next_tc    = 1'b0;
    lap_inc    = 1'b0;
    if (count > hi) begin
      // Bounds moved under us: pull back into range first, silently.
      next_count = hi;
    end else if (count < lo) begin
      next_count = lo;
    end else begin
      unique case (mode)
        MODE_UPWRAP: begin
          next_dir = DIR_UP;
          if (count == hi) begin
            next_count = lo;
            next_tc    = 1'b1;
          end else begin
            next_count = up_next;
          end
        end
        MODE_DNWRAP: begin
          next_dir = DIR_DN;
          if (count == lo) begin
            next_count = hi;
            next_tc    = 1'b1;
          end else begin
            next_count = dn_next;
          end
        end
        MODE_BOUNCE: begin
          // Turnaround and first step in the new direction share a cycle.
          if (dir == DIR_UP) begin
            if (count == hi) begin
              next_dir   = DIR_DN;
              next_count = dn_next;
              next_tc    = 1'b1;
            end else begin
              next_count = up_next;
            end
          end else begin
            if (count == lo) begin
              next_dir   = DIR_UP;
              next_count = up_next;
              next_tc    = 1'b1;
              lap_inc    = 1'b1;
            end else begin
              next_count = dn_next;
            end
          end
        end
        default: begin
          // MODE_HOLD: everything stays as it is.
        end
      endcase
    end
  end

endmodule

// File: rtl/pingpong_counter.sv
// pingpong_counter: up/down counter with runtime bounds, step and mode
// (up-wrap, down-wrap, bounce, hold), parallel load and a saturating
// count of completed bounce laps. All outputs are registered.
// Ports:
//   Clk       : clock, rising edge
//   reset     : synchronous, active-high
//   en        : advance enable (ignored while load=1)
//   mode      : 00 up-wrap, 01 down-wrap, 10 bounce, 11 hold
//   lo, hi    : inclusive bounds; hi<=lo parks the count at lo
//   step      : increment magnitude, 0 behaves as 1
//   load      : parallel load strobe, value clamped into [lo,hi]
//   load_val  : value to load
//   count     : current value
//   dir       : current direction, 0 up / 1 down
//   tc        : one-cycle pulse aligned with a wrapped/turned count
//   laps      : completed bounce round trips, saturating
module pingpong_counter
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic [LAP_W-1:0] laps
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [LAP_W-1:0] laps_q, laps_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] calc_count;
  logic             calc_dir;
  logic             calc_tc;
  logic             calc_lap;
  logic [WIDTH-1:0] load_clamped;

  assign s = (step == '0) ? WIDTH'(1) : step;

  pp_step_calc #(
    .WIDTH (WIDTH)
  ) u_step_calc (
    .count      (count_q),
    .dir        (dir_q),
    .mode       (mode),
    .lo         (lo),
    .hi         (hi),
    .s          (s),
    .next_count (calc_count),
    .next_dir   (calc_dir),
    .next_tc    (calc_tc),
    .lap_inc    (calc_lap)
  );

  always_comb begin
    if (load_val < lo) begin
      load_clamped = lo;
    end else if (load_val > hi) begin
      load_clamped = hi;
    end else begin
      load_clamped = load_val;
    end
  end

  // Priority below reset: load, invalid bounds, enabled advance.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    laps_d  = laps_q;
    if (load) begin
      count_d = load_clamped;
      if (mode == MODE_UPWRAP) begin
        dir_d = DIR_UP;
      end else if (mode == MODE_DNWRAP) begin
        dir_d = DIR_DN;
      end
    end else if (hi <= lo) begin
      count_d = lo;
    end else if (en) begin
      count_d = calc_count;
      dir_d   = calc_dir;
      tc_d    = calc_tc;
      if (calc_lap && (laps_q != '1)) begin
        laps_d = laps_q + {{(LAP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      tc_q    <= 1'b0;
      laps_q  <= '0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      laps_q  <= laps_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign laps  = laps_q;

endmodule
